word_byte_sequencer: RTL and testbench
======================================

# word_byte_sequencer

Sequences 32-bit words through the `splitter` byte datapath and emits them one byte per cycle on a valid/ready output stream. Upstream logic hands over one word at a time with a byte length; the block presents the selected bytes in order and flags the last one. It sits between a 32-bit word source and any 8-bit consumer, such as a byte bus or a display driver.

## Interface

Parameters:
- `MSB_FIRST`, default 1. When 1, bytes go out from `in_data[31:24]` down to `[7:0]`. When 0, they go out from `[7:0]` up to `[31:24]`.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: upstream word offered.
- `in_ready` output 1: block accepts the word this cycle.
- `in_data` input 32: word to serialize.
- `in_len` input 3: number of bytes to send, 1..4. Values 0 and 5..7 are treated as 4.
- `out_valid` output 1: `out_data` holds a byte.
- `out_ready` input 1: downstream accepts the byte.
- `out_data` output 8: current byte.
- `out_last` output 1: current byte is the final byte of its word.
- `busy` output 1: the block is in state SEND.
- `byte_count` output 16: running count of output handshakes.

## Operation

- Word handshake: `in_valid && in_ready` at a rising edge. Byte handshake: `out_valid && out_ready` at a rising edge.
- On a word handshake the block registers `in_data`, the normalized length (`len`) and `idx = 0`.
- The registered word drives a `splitter` instance, whose four outputs are the byte lanes.
- Byte selection:
  - `MSB_FIRST=1`: lane `idx`, where lane 0 is bits [31:24].
  - `MSB_FIRST=0`: lane `3-idx`.
  - For `len < 4`, only the first `len` bytes in the chosen order are sent.
- State IDLE:
  - `in_ready=1`, `out_valid=0`.
  - Word handshake goes to SEND.
- State SEND:
  - `out_valid=1`, `out_data` = selected byte, `out_last = (idx == len-1)`.
  - Byte handshake with `out_last=0`: `idx` increments.
  - Byte handshake with `out_last=1` and `in_valid=1`: load the new word, set `idx=0`, stay in SEND. There is no bubble.
  - Byte handshake with `out_last=1` and `in_valid=0`: go to IDLE.
- `in_ready` = IDLE, or (SEND && `out_ready` && `out_last`). This is a combinational path from `out_ready`, which is permitted.
- While `out_valid && !out_ready`, `out_data` and `out_last` stay stable and `idx` holds.
- `byte_count` increments by 1 per byte handshake and wraps from 0xFFFF to 0x0000.

## Timing

- Reset (`reset_n` low, asynchronous):
  - State goes to IDLE; `idx`, `len` and the registered word go to 0.
  - `out_valid=0`, `out_data=0x00`, `out_last=0`, `busy=0`, `byte_count=0`.
  - `in_ready` is forced to 0 while `reset_n` is low.
- Reset mid-word: the partially sent word is discarded with no further bytes. After release, the block is in IDLE with `in_ready=1`.
- Latency: a word accepted at edge N gives its first byte valid in the cycle after edge N. That output is registered, with no combinational path from input data to output data.
- Throughput: 1 byte per cycle when `out_ready` is held high. Back-to-back words stream continuously.
- `busy` and `out_valid` are identical.

## Structure

- Shared header `seq_defs.vh`: state encodings `ST_IDLE=1'b0` and `ST_SEND=1'b1`, and the length constant `MAX_LEN=3'd4`.
- One sub-module: `splitter`, instantiated on the registered word. Lane muxing, the FSM and the counter stay in this module.

## Test plan

- Reset, then `in_data=0xA1B2C3D4`, `in_len=4`, `out_ready=1`, `MSB_FIRST=1`:
  - Expected bytes A1, B2, C3, D4 on 4 consecutive cycles.
  - `out_last` high only on D4; `byte_count=4`; then IDLE.
- Same word with `MSB_FIRST=0` and `in_len=2`:
  - Expected bytes D4, C3; `out_last` on C3.
  - `in_len=0` on a following word gives all 4 bytes.
- Backpressure: drop `out_ready` for 3 cycles while B2 is presented.
  - B2 and `out_last=0` must hold stable, `idx` unchanged, `in_ready=0`.
- Back-to-back: a second word 0x11223344 is offered during the last byte of the first word.
  - Sequence must run D4 then 11 on consecutive cycles with no gap.
- Assert `reset_n` low for 1 cycle after the second byte of a 4-byte word:
  - All outputs go to their reset values immediately; no further bytes of that word appear.
  - A new word is accepted in the first cycle after release.
- Preload 0xFFFF handshakes, send one more byte: `byte_count` wraps to 0x0000.

Source files
------------

// File: rtl/word_byte_sequencer_pkg.sv
// Shared definitions for the word-to-byte sequencer: FSM state encoding,
// the maximum byte length of a word and the length normalization helper.
package word_byte_sequencer_pkg;

   // Sequencer states: waiting for a word, or streaming its bytes out.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } seq_state_t;

   // A word carries at most four bytes.
   localparam logic [2:0] MAX_LEN = 3'd4;

   // Number of byte lanes produced by the splitter.
   localparam int unsigned NUM_LANES = 4;

   // Lengths outside 1..4 (0 and 5..7) mean "send the whole word".
   function automatic logic [2:0] normalize_len(input logic [2:0] raw_len);
      logic [2:0] result;
      if ((raw_len == 3'd0) || (raw_len > MAX_LEN)) begin
         result = MAX_LEN;
      end else begin
         result = raw_len;
      end
      return result;
   endfunction

endpackage

// File: rtl/word_byte_sequencer_splitter.sv
// Byte datapath for the sequencer: splits a 32-bit word into its four byte
// lanes. Lane 0 is the most significant byte, lane 3 the least significant.
module splitter (
   input  logic [31:0] word,
   output logic [7:0]  lane0,
   output logic [7:0]  lane1,
   output logic [7:0]  lane2,
   output logic [7:0]  lane3
);

   // Pure wiring: each lane is one byte of the registered word.
   assign lane0 = word[31:24];
   assign lane1 = word[23:16];
   assign lane2 = word[15:8];
   assign lane3 = word[7:0];

endmodule

// File: rtl/word_byte_sequencer.sv
// Serializes 32-bit words into a valid/ready byte stream. One word is held at
// a time; its bytes leave in MSB-first or LSB-first order and the final byte
// of each word is flagged. A new word can be taken on the same edge as the
// last byte of the previous one, so back-to-back words stream without a gap.
module word_byte_sequencer #(
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic [2:0]  in_len,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_data,
   output logic        out_last,
   output logic        busy,
   output logic [15:0] byte_count
);

   import word_byte_sequencer_pkg::*;

   seq_state_t  state;
   logic [31:0] word_q;
   logic [2:0]  len_q;
   logic [1:0]  idx_q;
   logic [15:0] byte_count_q;

   logic [7:0]  lane0;
   logic [7:0]  lane1;
   logic [7:0]  lane2;
   logic [7:0]  lane3;
   logic [1:0]  lane_sel;
   logic [7:0]  sel_byte;
   logic        sending;
   logic        is_last;
   logic        word_hs;
   logic        byte_hs;

   // The splitter only ever sees the registered word, so output data never
   // depends combinationally on in_data.
   splitter u_splitter (
      .word  (word_q),
      .lane0 (lane0),
      .lane1 (lane1),
      .lane2 (lane2),
      .lane3 (lane3)
   );

   assign sending = (state == ST_SEND);

   // LSB-first order walks the lanes backwards starting at the low byte.
   assign lane_sel = MSB_FIRST ? idx_q : (2'd3 - idx_q);

   // Pick the byte lane addressed by the current position in the word.
   always_comb begin
      sel_byte = 8'h00;
      case (lane_sel)
         2'd0:    sel_byte = lane0;
         2'd1:    sel_byte = lane1;
         2'd2:    sel_byte = lane2;
         default: sel_byte = lane3;
      endcase
   end

   // len_q is always 1..4 while sending, so len_q-1 never underflows here.
   assign is_last = sending && ({1'b0, idx_q} == (len_q - 3'd1));

   // The upstream port opens while idle, or on the final byte of a word that
   // the consumer is taking right now; held closed throughout reset.
   assign in_ready = reset_n && ((state == ST_IDLE) || (out_ready && is_last));

   assign word_hs = in_valid && in_ready;
   assign byte_hs = sending && out_ready;

   assign out_valid  = sending;
   assign busy       = sending;
   assign out_data   = sending ? sel_byte : 8'h00;
   assign out_last   = is_last;
   assign byte_count = byte_count_q;

   // Sequencer FSM: loads words, advances the byte index on each handshake and
   // keeps the running count of bytes delivered.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         word_q       <= 32'h0000_0000;
         len_q        <= 3'd0;
         idx_q        <= 2'd0;
         byte_count_q <= 16'h0000;
      end else begin
         if (word_hs) begin
            word_q <= in_data;
            len_q  <= normalize_len(in_len);
            idx_q  <= 2'd0;
            state  <= ST_SEND;
         end else if (byte_hs && is_last) begin
            state <= ST_IDLE;
         end else if (byte_hs) begin
            idx_q <= idx_q + 2'd1;
         end
         if (byte_hs) begin
            byte_count_q <= byte_count_q + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_word_byte_sequencer.sv
// Directed bench for word_byte_sequencer. Two instances share every input:
// dut_m streams MSB first, dut_l streams LSB first, so each step checks both
// byte orders against hand-computed values.
module tb_word_byte_sequencer;

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic [31:0] in_data;
   logic [2:0]  in_len;
   logic        out_ready;

   logic        m_in_ready;
   logic        m_out_valid;
   logic [7:0]  m_out_data;
   logic        m_out_last;
   logic        m_busy;
   logic [15:0] m_byte_count;

   logic        l_in_ready;
   logic        l_out_valid;
   logic [7:0]  l_out_data;
   logic        l_out_last;
   logic        l_busy;
   logic [15:0] l_byte_count;

   int tests_run;
   int tests_failed;

   word_byte_sequencer #(.MSB_FIRST(1'b1)) dut_m (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (m_in_ready),
      .in_data    (in_data),
      .in_len     (in_len),
      .out_valid  (m_out_valid),
      .out_ready  (out_ready),
      .out_data   (m_out_data),
      .out_last   (m_out_last),
      .busy       (m_busy),
      .byte_count (m_byte_count)
   );

   word_byte_sequencer #(.MSB_FIRST(1'b0)) dut_l (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (l_in_ready),
      .in_data    (in_data),
      .in_len     (in_len),
      .out_valid  (l_out_valid),
      .out_ready  (out_ready),
      .out_data   (l_out_data),
      .out_last   (l_out_last),
      .busy       (l_busy),
      .byte_count (l_byte_count)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus(input logic v, input logic [31:0] data, input logic [2:0] len,
                                 input logic rdy);
      in_valid  = v;
      in_data   = data;
      in_len    = len;
      out_ready = rdy;
   endtask

   // Both instances presenting a byte: data per order, shared last flag.
   task automatic check_byte(input string tag, input logic [7:0] exp_m, input logic [7:0] exp_l,
                             input logic exp_last, input logic [15:0] exp_count);
      check_output({tag, ".m_valid"}, {31'd0, m_out_valid}, 32'd1);
      check_output({tag, ".m_busy"},  {31'd0, m_busy},      32'd1);
      check_output({tag, ".m_data"},  {24'd0, m_out_data},  {24'd0, exp_m});
      check_output({tag, ".m_last"},  {31'd0, m_out_last},  {31'd0, exp_last});
      check_output({tag, ".l_data"},  {24'd0, l_out_data},  {24'd0, exp_l});
      check_output({tag, ".l_last"},  {31'd0, l_out_last},  {31'd0, exp_last});
      check_output({tag, ".count"},   {16'd0, m_byte_count}, {16'd0, exp_count});
   endtask

   // Both instances idle with the given handshake count.
   task automatic check_idle(input string tag, input logic [15:0] exp_count,
                             input logic exp_in_ready);
      check_output({tag, ".m_valid"},  {31'd0, m_out_valid},  32'd0);
      check_output({tag, ".l_valid"},  {31'd0, l_out_valid},  32'd0);
      check_output({tag, ".m_busy"},   {31'd0, m_busy},       32'd0);
      check_output({tag, ".m_data"},   {24'd0, m_out_data},   32'd0);
      check_output({tag, ".m_last"},   {31'd0, m_out_last},   32'd0);
      check_output({tag, ".m_count"},  {16'd0, m_byte_count}, {16'd0, exp_count});
      check_output({tag, ".l_count"},  {16'd0, l_byte_count}, {16'd0, exp_count});
      check_output({tag, ".m_in_rdy"}, {31'd0, m_in_ready},   {31'd0, exp_in_ready});
      check_output({tag, ".l_in_rdy"}, {31'd0, l_in_ready},   {31'd0, exp_in_ready});
   endtask

   // Linear directed sequence; inputs change and outputs are sampled on the
   // falling edge, midway between active edges.
   initial begin
      int budget;
      tests_run    = 0;
      tests_failed = 0;
      reset_n      = 1'b0;
      apply_stimulus(1'b0, 32'h0, 3'd0, 1'b0);

      // Reset state.
      repeat (2) @(negedge clk);
      check_idle("reset", 16'h0000, 1'b0);
      reset_n = 1'b1;

      // Word 1: A1B2C3D4, length 4, consumer always ready.
      @(negedge clk);
      check_idle("idle0", 16'h0000, 1'b1);
      apply_stimulus(1'b1, 32'hA1B2_C3D4, 3'd4, 1'b1);
      @(negedge clk);
      check_byte("w1b0", 8'hA1, 8'hD4, 1'b0, 16'd0);
      in_valid = 1'b0;
      @(negedge clk);
      check_byte("w1b1", 8'hB2, 8'hC3, 1'b0, 16'd1);
      @(negedge clk);
      check_byte("w1b2", 8'hC3, 8'hB2, 1'b0, 16'd2);
      @(negedge clk);
      check_byte("w1b3", 8'hD4, 8'hA1, 1'b1, 16'd3);
      check_output("w1b3.in_rdy", {31'd0, m_in_ready}, 32'd1);
      @(negedge clk);
      check_idle("w1done", 16'd4, 1'b1);

      // Word 2: same word, length 2.
      apply_stimulus(1'b1, 32'hA1B2_C3D4, 3'd2, 1'b1);
      @(negedge clk);
      check_byte("w2b0", 8'hA1, 8'hD4, 1'b0, 16'd4);
      check_output("w2b0.in_rdy", {31'd0, m_in_ready}, 32'd0);
      in_valid = 1'b0;
      @(negedge clk);
      check_byte("w2b1", 8'hB2, 8'hC3, 1'b1, 16'd5);
      @(negedge clk);
      check_idle("w2done", 16'd6, 1'b1);

      // Word 3: length 0 means all four bytes.
      apply_stimulus(1'b1, 32'hA1B2_C3D4, 3'd0, 1'b1);
      @(negedge clk);
      check_byte("w3b0", 8'hA1, 8'hD4, 1'b0, 16'd6);
      in_valid = 1'b0;
      @(negedge clk);
      check_byte("w3b1", 8'hB2, 8'hC3, 1'b0, 16'd7);
      @(negedge clk);
      check_byte("w3b2", 8'hC3, 8'hB2, 1'b0, 16'd8);
      @(negedge clk);
      check_byte("w3b3", 8'hD4, 8'hA1, 1'b1, 16'd9);
      @(negedge clk);
      check_idle("w3done", 16'd10, 1'b1);

      // Word 4: backpressure for three edges while the second byte is shown,
      // then a back-to-back word offered during its last byte.
      apply_stimulus(1'b1, 32'hA1B2_C3D4, 3'd4, 1'b1);
      @(negedge clk);
      check_byte("w4b0", 8'hA1, 8'hD4, 1'b0, 16'd10);
      in_valid = 1'b0;
      @(negedge clk);
      check_byte("w4b1", 8'hB2, 8'hC3, 1'b0, 16'd11);
      out_ready = 1'b0;
      #1;
      check_output("bp.in_rdy0", {31'd0, m_in_ready}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_byte("bp.hold", 8'hB2, 8'hC3, 1'b0, 16'd11);
         check_output("bp.in_rdy", {31'd0, m_in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check_byte("w4b2", 8'hC3, 8'hB2, 1'b0, 16'd12);
      @(negedge clk);
      check_byte("w4b3", 8'hD4, 8'hA1, 1'b1, 16'd13);
      apply_stimulus(1'b1, 32'h1122_3344, 3'd4, 1'b1);
      #1;
      check_output("b2b.in_rdy", {31'd0, m_in_ready}, 32'd1);
      @(negedge clk);
      check_byte("w5b0", 8'h11, 8'h44, 1'b0, 16'd14);
      in_valid = 1'b0;
      @(negedge clk);
      check_byte("w5b1", 8'h22, 8'h33, 1'b0, 16'd15);
      @(negedge clk);
      check_byte("w5b2", 8'h33, 8'h22, 1'b0, 16'd16);

      // Asynchronous reset mid-word: outputs clear at once, no more bytes.
      reset_n = 1'b0;
      #1;
      check_idle("rst_mid", 16'h0000, 1'b0);
      @(negedge clk);
      check_idle("rst_hold", 16'h0000, 1'b0);
      reset_n = 1'b1;
      apply_stimulus(1'b1, 32'h5566_7788, 3'd1, 1'b1);
      #1;
      check_output("rel.in_rdy", {31'd0, m_in_ready}, 32'd1);
      @(negedge clk);
      check_byte("w6b0", 8'h55, 8'h88, 1'b1, 16'd0);
      in_valid = 1'b0;
      @(negedge clk);
      check_idle("w6done", 16'd1, 1'b1);

      // Counter wrap: stream continuously until 0xFFFF handshakes, then one more.
      apply_stimulus(1'b1, 32'h0F0E_0D0C, 3'd4, 1'b1);
      budget = 70000;
      while ((m_byte_count != 16'hFFFF) && (budget > 0)) begin
         @(negedge clk);
         budget--;
      end
      check_output("wrap.budget", {31'd0, (budget > 0)}, 32'd1);
      check_output("wrap.l_ffff", {16'd0, l_byte_count}, 32'h0000_FFFF);
      check_output("wrap.valid", {31'd0, m_out_valid}, 32'd1);
      @(negedge clk);
      check_output("wrap.m_zero", {16'd0, m_byte_count}, 32'h0000_0000);
      check_output("wrap.l_zero", {16'd0, l_byte_count}, 32'h0000_0000);
      in_valid = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
